// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// branch_predictor_pkg : shared counter encodings and widths for the predictor
// Revision 1.0
// ============================================================================
`default_nettype none

package branch_predictor_pkg;

   localparam int WORD_W = 32;

   typedef logic [1:0] cnt2_t;

   localparam cnt2_t SNT = 2'b00;
   localparam cnt2_t WNT = 2'b01;
   localparam cnt2_t WT  = 2'b10;
   localparam cnt2_t ST  = 2'b11;

   localparam cnt2_t CNT_RESET = WNT;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_cnt2.sv
// ============================================================================
// sat_cnt2 : next-state logic of a 2-bit saturating direction counter
// Revision 1.0
// ============================================================================
`default_nettype none

module sat_cnt2
   import branch_predictor_pkg::*;
(
   input  cnt2_t cur_state,
   input  logic  taken,
   output cnt2_t next_state
);

   always_comb begin
      next_state = cur_state;
      if (taken) begin
         if (cur_state != ST) next_state = cur_state + 2'd1;
      end else begin
         if (cur_state != SNT) next_state = cur_state - 2'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor : gshare 2-bit counter predictor with ID-stage resolution
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int IDX_W = 6,
   parameter int GHR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] if_pc,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_pred,
   input  logic              upd_taken,
   input  logic [WORD_W-1:0] upd_pc,
   input  logic [WORD_W-1:0] upd_target,
   output logic              mispredict,
   output logic [WORD_W-1:0] redirect_pc,
   output logic [WORD_W-1:0] br_count,
   output logic [WORD_W-1:0] miss_count
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam logic [WORD_W-1:0] CNT_MAX = '1;

   cnt2_t             tbl [ENTRIES];
   logic [GHR_W-1:0]  ghr;
   logic [GHR_W-1:0]  ghr_next;
   cnt2_t             upd_cur;
   cnt2_t             upd_next;

   logic unused_pc_bits;
   assign unused_pc_bits = &{1'b0, if_pc[WORD_W-1:IDX_W+2], if_pc[1:0]};

   // History is zero-extended onto the low index bits.
   assign pred_idx   = if_pc[IDX_W+1:2] ^ IDX_W'(ghr);
   assign pred_taken = tbl[pred_idx][1];

   assign mispredict  = upd_valid & ~reset & (upd_taken != upd_pred);
   assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd8;

   assign upd_cur = tbl[upd_idx];

   sat_cnt2 u_sat_cnt2 (
      .cur_state  (upd_cur),
      .taken      (upd_taken),
      .next_state (upd_next)
   );

   generate
      if (GHR_W == 1) begin : g_ghr_single
         assign ghr_next = upd_taken;
      end else begin : g_ghr_shift
         assign ghr_next = {ghr[GHR_W-2:0], upd_taken};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= CNT_RESET;
         ghr        <= '0;
         br_count   <= '0;
         miss_count <= '0;
      end else if (upd_valid) begin
         tbl[upd_idx] <= upd_next;
         ghr          <= ghr_next;
         if (br_count != CNT_MAX) br_count <= br_count + 32'd1;
         if (mispredict && miss_count != CNT_MAX) miss_count <= miss_count + 32'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// tb_branch_predictor : directed + randomized check against a behavioural model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;

   localparam int IDX_W = 6;
   localparam int GHR_W = 4;
   localparam int ENT   = 1 << IDX_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       if_pc;
   logic              pred_taken;
   logic [IDX_W-1:0]  pred_idx;
   logic              upd_valid;
   logic [IDX_W-1:0]  upd_idx;
   logic              upd_pred;
   logic              upd_taken;
   logic [31:0]       upd_pc;
   logic [31:0]       upd_target;
   logic              mispredict;
   logic [31:0]       redirect_pc;
   logic [31:0]       br_count;
   logic [31:0]       miss_count;

   always #5 clk = ~clk;

   branch_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .if_pc       (if_pc),
      .pred_taken  (pred_taken),
      .pred_idx    (pred_idx),
      .upd_valid   (upd_valid),
      .upd_idx     (upd_idx),
      .upd_pred    (upd_pred),
      .upd_taken   (upd_taken),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .mispredict  (mispredict),
      .redirect_pc (redirect_pc),
      .br_count    (br_count),
      .miss_count  (miss_count)
   );

   // reference state: counters as small integers 0..3
   int          m_tbl [ENT];
   int          m_ghr;
   longint      m_br;
   longint      m_miss;

   int total = 0;
   int bad   = 0;

   logic        obs_pred;
   logic        obs_mis;
   logic [31:0] obs_rpc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pc_for(input int idx);
      return 32'(((idx ^ m_ghr) & (ENT - 1)) << 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENT; i++) m_tbl[i] = 1;
      m_ghr  = 0;
      m_br   = 0;
      m_miss = 0;
   endtask

   // One cycle: drive, check combinational outputs against the model, then clock.
   task automatic cycle(input logic r, input logic v, input int ui, input logic up,
                        input logic ut, input logic [31:0] upc, input logic [31:0] utg,
                        input logic [31:0] ipc);
      int          e_idx;
      logic        e_mis;
      logic [31:0] e_rpc;
      @(negedge clk);
      reset = r; upd_valid = v; upd_idx = IDX_W'(ui); upd_pred = up;
      upd_taken = ut; upd_pc = upc; upd_target = utg; if_pc = ipc;
      #1;
      e_idx = ((ipc >> 2) & (ENT - 1)) ^ m_ghr;
      e_mis = v && !r && (ut != up);
      e_rpc = ut ? utg : upc + 32'd8;
      chk("pred_idx", 32'(pred_idx), 32'(e_idx));
      chk("pred_taken", 32'(pred_taken), 32'(m_tbl[e_idx] >= 2));
      chk("mispredict", 32'(mispredict), 32'(e_mis));
      if (e_mis) chk("redirect_pc", redirect_pc, e_rpc);
      chk("br_count", br_count, 32'(m_br));
      chk("miss_count", miss_count, 32'(m_miss));
      obs_pred = pred_taken; obs_mis = mispredict; obs_rpc = redirect_pc;
      @(posedge clk);
      if (r) model_reset();
      else if (v) begin
         m_tbl[ui] = ut ? ((m_tbl[ui] < 3) ? m_tbl[ui] + 1 : 3)
                        : ((m_tbl[ui] > 0) ? m_tbl[ui] - 1 : 0);
         m_ghr = ((m_ghr << 1) | int'(ut)) & ((1 << GHR_W) - 1);
         if (m_br < 64'hFFFF_FFFF) m_br++;
         if (e_mis && m_miss < 64'hFFFF_FFFF) m_miss++;
      end
   endtask

   task automatic idle(input logic [31:0] ipc);
      cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0, ipc);
   endtask

   initial begin
      reset = 1'b1; upd_valid = 1'b0; upd_idx = '0; upd_pred = 1'b0;
      upd_taken = 1'b0; upd_pc = '0; upd_target = '0; if_pc = '0;
      repeat (2) @(posedge clk);
      model_reset();

      // 1: reset state
      idle(32'h0000_3000);
      chk("t1_idx", 32'(pred_idx), 32'h0);
      chk("t1_pred", 32'(obs_pred), 32'h0);
      chk("t1_mis", 32'(obs_mis), 32'h0);
      chk("t1_br", br_count, 32'h0);

      // 2: taken-path training on entry 5
      cycle(1'b0, 1'b1, 5, 1'b0, 1'b1, 32'h0000_3010, 32'h0000_3040, 32'h0000_3000);
      chk("t2_mis", 32'(obs_mis), 32'h1);
      chk("t2_rpc", obs_rpc, 32'h0000_3040);
      cycle(1'b0, 1'b1, 5, 1'b0, 1'b1, 32'h0000_3010, 32'h0000_3040, 32'h0000_3000);
      idle(32'h0000_3018);
      chk("t2_idx", 32'(pred_idx), 32'd5);
      chk("t2_pred", 32'(obs_pred), 32'h1);
      chk("t2_br", br_count, 32'd2);
      chk("t2_miss", miss_count, 32'd2);

      // 3: saturation at ST, then one not-taken step back to WT
      repeat (3) cycle(1'b0, 1'b1, 5, 1'b1, 1'b1, 32'h0000_3010, 32'h0000_3040, 32'h0);
      idle(pc_for(5));
      chk("t3_st", 32'(obs_pred), 32'h1);
      cycle(1'b0, 1'b1, 5, 1'b1, 1'b0, 32'h0000_3010, 32'h0000_3040, 32'h0);
      idle(pc_for(5));
      chk("t3_wt", 32'(obs_pred), 32'h1);

      // 4: not-taken miss redirects past the delay slot, then a correct prediction
      cycle(1'b0, 1'b1, 9, 1'b1, 1'b0, 32'h0000_3010, 32'h0000_3040, 32'h0);
      chk("t4_mis", 32'(obs_mis), 32'h1);
      chk("t4_rpc", obs_rpc, 32'h0000_3018);
      idle(32'h0);
      cycle(1'b0, 1'b1, 9, 1'b0, 1'b0, 32'h0000_3010, 32'h0000_3040, 32'h0);
      chk("t4_ok", 32'(obs_mis), 32'h0);
      idle(32'h0);
      chk("t4_miss", miss_count, 32'd4);

      // 5: same-cycle read/write of entry 0 returns pre-update value
      cycle(1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h0, 32'h0000_4000, pc_for(0));
      chk("t5_old", 32'(obs_pred), 32'h0);
      idle(pc_for(0));
      chk("t5_new", 32'(obs_pred), 32'h1);

      // 6: reset beats a coincident update
      cycle(1'b1, 1'b1, 5, 1'b0, 1'b1, 32'h0, 32'h0000_5000, 32'h0);
      chk("t6_mis", 32'(obs_mis), 32'h0);
      idle(32'h0);
      chk("t6_br", br_count, 32'h0);
      chk("t6_miss", miss_count, 32'h0);
      for (int i = 0; i < ENT; i++) begin
         if_pc = 32'(i << 2);
         #1;
         chk("t6_clear", 32'(pred_taken), 32'h0);
         chk("t6_ghr", 32'(pred_idx), 32'(i));
      end

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
               int'($urandom_range(0, ENT - 1)), 1'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
